// File: rtl/ps2_rx_fsm.sv
// PS/2 device-to-host frame receiver.
// Synchronizes the raw PS/2 pins and detects ps2_clk falling edges. A state
// machine assembles start/8 data/odd parity/stop frames, publishes good bytes
// with a one-cycle strobe, and flags bad frames with a separate strobe. An
// inter-edge watchdog drops frames that stall partway through.
module ps2_rx_fsm #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_en,
    output logic [2:0] estado,
    output logic [7:0] dato,
    output logic       dato_listo,
    output logic       error_trama
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        RECIBE  = 3'b001,
        PARIDAD = 3'b010,
        STOP    = 3'b011,
        LISTO   = 3'b100,
        ERROR   = 3'b101
    } state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fe_q, fe_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          par_q, par_d;
    logic [7:0]    dato_q, dato_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit, in_frame;

    // Synchronizers and edge-detect pipeline. Idle level of the PS/2 bus is
    // high, so the flops reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            fe_q       <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            fe_q       <= fe_d;
        end
    end

    // State register and frame datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            dato_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            dato_q  <= dato_d;
            tmo_q   <= tmo_d;
        end
    end

    assign fe_d     = clk_prev_q & ~clk_s2_q;
    assign in_frame = (state_q == RECIBE) || (state_q == PARIDAD) || (state_q == STOP);
    assign tmo_hit  = (tmo_q == TMO_MAX);

    // Next-state logic; a falling edge takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fe_q && rx_en && !dat_s2_q) state_d = RECIBE;
            RECIBE:  if (fe_q) begin
                         if (cnt_q == 3'd7) state_d = PARIDAD;
                     end else if (tmo_hit) state_d = IDLE;
                     else state_d = RECIBE;
            PARIDAD: if (fe_q) state_d = STOP;
                     else if (tmo_hit) state_d = IDLE;
                     else state_d = PARIDAD;
            STOP:    if (fe_q) state_d = (dat_s2_q && ((^shift_q) ^ par_q)) ? LISTO : ERROR;
                     else if (tmo_hit) state_d = IDLE;
                     else state_d = STOP;
            LISTO:   state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: shift register, bit counter, parity, output byte, watchdog.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        dato_d  = dato_q;
        tmo_d   = tmo_q;
        if (state_q == IDLE && state_d == RECIBE) cnt_d = '0;
        if (state_q == RECIBE && fe_q) begin
            shift_d = {dat_s2_q, shift_q[7:1]};
            cnt_d   = cnt_q + 3'd1;
        end
        if (state_q == PARIDAD && fe_q) par_d = dat_s2_q;
        // Load on entry to LISTO so the new byte is visible with the strobe.
        if (state_q == STOP && state_d == LISTO) dato_d = shift_q;
        if (fe_q || !in_frame) tmo_d = '0;
        else if (!tmo_hit)     tmo_d = tmo_q + TW'(1);
    end

    // Outputs decoded from the registered state; strobes are mutually exclusive.
    always_comb begin
        estado      = state_q;
        dato        = dato_q;
        dato_listo  = (state_q == LISTO);
        error_trama = (state_q == ERROR);
    end

endmodule

// File: tb/tb_ps2_rx_fsm.sv
// Directed bench for ps2_rx_fsm: good frames, parity/stop errors, watchdog
// abort, mid-frame reset, and rx_en gating.
module tb_ps2_rx_fsm;

    localparam int TMO  = 5000;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_en = 1'b1;
    logic [2:0] estado;
    logic [7:0] dato;
    logic       dato_listo, error_trama;

    int checks = 0;
    int failures = 0;
    int lst_n = 0, err_n = 0, both_n = 0;
    logic [2:0] prev_est = 3'd0;
    logic [2:0] est_log[$];

    ps2_rx_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
        .estado(estado), .dato(dato), .dato_listo(dato_listo), .error_trama(error_trama)
    );

    always #5 clk = ~clk;

    // Strobe counters and log of every estado change, sampled mid-cycle.
    always @(negedge clk) begin
        if (dato_listo) lst_n <= lst_n + 1;
        if (error_trama) err_n <= err_n + 1;
        if (dato_listo && error_trama) both_n <= both_n + 1;
        if (estado !== prev_est) begin
            est_log.push_back(estado);
            prev_est <= estado;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] seq_pack();
        logic [31:0] v = '0;
        foreach (est_log[i]) v = (v << 3) | 32'(est_log[i]);
        return v;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic drop_en);
        send_bit(1'b0);
        if (drop_en) rx_en = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_log();
        @(negedge clk);
        est_log.delete();
    endtask

    initial begin
        logic [7:0] b12;
        int l0, e0;
        b12 = 8'h12;

        // Reset state while rst is held low
        #1;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_dato", 32'(dato), 32'h00);
        chk("rst_listo", 32'(dato_listo), 32'd0);
        chk("rst_err", 32'(error_trama), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0x1C
        clear_log();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("1c_seq_len", 32'(est_log.size()), 32'd5);
        chk("1c_seq", seq_pack(), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd0}));
        chk("1c_dato", 32'(dato), 32'h1C);
        chk("1c_listo_cnt", 32'(lst_n), 32'd1);
        chk("1c_err_cnt", 32'(err_n), 32'd0);

        // Bad parity 0xF0
        clear_log();
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        chk("f0_seq", seq_pack(), 32'({3'd1, 3'd2, 3'd3, 3'd5, 3'd0}));
        chk("f0_err_cnt", 32'(err_n), 32'd1);
        chk("f0_listo_cnt", 32'(lst_n), 32'd1);
        chk("f0_dato", 32'(dato), 32'h1C);

        // Bad stop bit 0xAA
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0);
        ps2_data = 1'b1;
        chk("aa_err_cnt", 32'(err_n), 32'd2);
        chk("aa_listo_cnt", 32'(lst_n), 32'd1);
        chk("aa_dato", 32'(dato), 32'h1C);

        // Stalled frame: start + 4 data bits, then watchdog abort
        clear_log();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_estado", 32'(estado), 32'd0);
        chk("tmo_seq", seq_pack(), 32'({3'd1, 3'd0}));
        chk("tmo_listo_cnt", 32'(lst_n), 32'd1);
        chk("tmo_err_cnt", 32'(err_n), 32'd2);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        chk("5a_dato", 32'(dato), 32'h5A);
        chk("5a_listo_cnt", 32'(lst_n), 32'd2);

        // Reset after the 5th data bit
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b12[i]);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("mrst_estado", 32'(estado), 32'd0);
        chk("mrst_dato", 32'(dato), 32'h00);
        chk("mrst_listo", 32'(dato_listo), 32'd0);
        chk("mrst_err", 32'(error_trama), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        chk("12_dato", 32'(dato), 32'h12);
        chk("12_listo_cnt", 32'(lst_n), 32'd3);

        // Receiver disabled: frame ignored
        clear_log();
        l0 = lst_n; e0 = err_n;
        rx_en = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("dis_seq_len", 32'(est_log.size()), 32'd0);
        chk("dis_listo", 32'(lst_n - l0), 32'd0);
        chk("dis_err", 32'(err_n - e0), 32'd0);
        chk("dis_dato", 32'(dato), 32'h12);

        // rx_en dropped after the start bit: frame still completes
        rx_en = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        chk("drop_dato", 32'(dato), 32'h1C);
        chk("drop_listo", 32'(lst_n - l0), 32'd1);
        chk("both_strobes", 32'(both_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
